// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | Opcode map, result-entry type and reference ALU evaluation function.       |
// | Optional ALU_RESPONDER_OVF_EN adds a signed-overflow bit to each entry.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] z;
        logic             ex;
        logic             err;
`ifdef ALU_RESPONDER_OVF_EN
        logic             ovf;
`endif
    } alu_entry_t;

    function automatic alu_entry_t alu_eval(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic [2:0]       op
    );
        alu_entry_t       r;
        logic [ALU_W-1:0] sum;
        logic [ALU_W-1:0] diff;
        r    = '0;
        sum  = a + b;
        diff = a - b;
        case (op)
            OP_AND: r.z = a & b;
            OP_OR:  r.z = a | b;
            OP_ADD: begin
                r.z = sum;
`ifdef ALU_RESPONDER_OVF_EN
                r.ovf = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
`endif
            end
            OP_SUB: begin
                r.z = diff;
`ifdef ALU_RESPONDER_OVF_EN
                r.ovf = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
`endif
            end
            OP_SLT:  r.z = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r.err = 1'b1;
        endcase
        r.ex = (r.z == '0);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rsp_fifo                                                               |
// | Synchronous result FIFO; the head output holds its last value when empty.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_rsp_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last;
    logic              w_empty;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
            // Track the visible head so the output stays put once the FIFO drains.
            if (!w_empty) begin
                r_last <= r_mem[r_rd_ptr];
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = w_empty ? r_last : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_responder                                                              |
// | Valid/ready ALU request/response wrapper: one compute stage, result FIFO.  |
// | Define ALU_RESPONDER_OVF_EN to add the rsp_ovf signed-overflow output.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_ex,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_count
`ifdef ALU_RESPONDER_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_FW  = c_PTR_W + 1;
    localparam int c_ENTRY_W = $bits(alu_entry_t);

    logic                r_stage_valid;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2:0]          r_op;
    logic [CNT_W-1:0]    r_rsp_count;

    logic                w_accept;
    logic                w_pop;
    logic                w_fifo_empty;
    logic [c_CNT_FW-1:0] w_fifo_count;
    logic [c_CNT_FW-1:0] w_occupancy;
    alu_entry_t          w_result;
    alu_entry_t          w_head;

    // The in-flight stage result counts against FIFO space, so a push never stalls.
    assign w_occupancy = w_fifo_count + c_CNT_FW'(r_stage_valid);
    assign req_ready   = (w_occupancy < c_CNT_FW'(DEPTH));
    assign w_accept    = req_valid && req_ready;
    assign w_pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_rsp_count   <= '0;
        end else begin
            r_stage_valid <= w_accept;
            if (w_accept) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_op <= req_op;
            end
            if (w_pop) begin
                r_rsp_count <= r_rsp_count + CNT_W'(1);
            end
        end
    end

    assign w_result = alu_eval(r_a, r_b, r_op);

    alu_rsp_fifo #(
        .DATA_W (c_ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_stage_valid),
        .i_push_data (w_result),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    assign rsp_valid = !w_fifo_empty;
    assign rsp_z     = w_head.z;
    assign rsp_ex    = w_head.ex;
    assign rsp_err   = w_head.err;
    assign rsp_count = r_rsp_count;
`ifdef ALU_RESPONDER_OVF_EN
    assign rsp_ovf   = w_head.ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_responder                                                           |
// | Scoreboard bench for alu_responder; ALU_RESPONDER_OVF_EN adds ovf checks.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_responder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_ex;
    logic             rsp_err;
    logic [CNT_W-1:0] rsp_count;
    logic             ovf_obs;
    logic [34:0]      obs;

    int          passed = 0;
    int          total  = 0;
    logic [34:0] sb_q[$];
    int unsigned n_pops = 0;
    logic        prev_stall = 1'b0;
    logic        have_prev  = 1'b0;
    logic [34:0] prev_obs;
    logic        rnd_on = 1'b0;

    always #5 clk = ~clk;

    alu_responder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_ex    (rsp_ex),
        .rsp_err   (rsp_err),
        .rsp_count (rsp_count)
`ifdef ALU_RESPONDER_OVF_EN
        ,
        .rsp_ovf   (ovf_obs)
`endif
    );

`ifndef ALU_RESPONDER_OVF_EN
    assign ovf_obs = 1'b0;
`endif
    assign obs = {ovf_obs, rsp_err, rsp_ex, rsp_z};

    // Reference: {ovf, err, ex, z}, written independently of the RTL package.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] z;
        logic [32:0] s;
        logic        err;
        logic        ovf;
        err = 1'b0;
        ovf = 1'b0;
        z   = '0;
        s   = '0;
        case (op)
            3'b000: z = a & b;
            3'b001: z = a | b;
            3'b010: begin
                s = {a[31], a} + {b[31], b};
                z = s[31:0];
                ovf = s[32] ^ s[31];
            end
            3'b110: begin
                s = {a[31], a} - {b[31], b};
                z = s[31:0];
                ovf = s[32] ^ s[31];
            end
            3'b111: z = ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
`ifndef ALU_RESPONDER_OVF_EN
        ovf = 1'b0;
`endif
        return {ovf, err, (z == 32'd0), z};
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            have_prev  = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                sb_q.push_back(model(req_a, req_b, req_op));
            end
            if (rsp_valid && prev_stall) begin
                check("rsp_hold", obs, prev_obs);
            end
            if (!rsp_valid && have_prev) begin
                check("idle_hold", obs, prev_obs);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 0, 1);
                end else begin
                    check("rsp_data", obs, sb_q.pop_front());
                end
                n_pops++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_obs   = obs;
            have_prev  = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && sb_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt0;
        logic [15:0] dcnt;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_count", rsp_count, 0);
        check("rst_z", rsp_z, 0);
        check("rst_ex", rsp_ex, 0);
        check("rst_err", rsp_err, 0);
        check("rst_ovf", ovf_obs, 0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single add
        send(32'd5, 32'd3, 3'b010);
        check("lat_valid_early", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", rsp_valid, 1);
        check("lat_z", rsp_z, 8);
        check("lat_ex", rsp_ex, 0);
        check("lat_err", rsp_err, 0);
        @(posedge clk);
        #1;
        check("lat_count", rsp_count, 1);

        // Directed opcodes
        send(32'd7, 32'd7, 3'b110);
        send(32'hFFFFFFFF, 32'd1, 3'b111);
        send(32'h12345, 32'h6789, 3'b011);
        send(32'hF0, 32'h3C, 3'b000);
        wait_drain();
        check("hold_z_after_drain", rsp_z, 32'h30);
        check("hold_err_after_drain", rsp_err, 0);
        check("count_5", rsp_count, 5);

        // Backpressure: reservation closes after DEPTH accepts
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(i + 1, 10 * i, 3'b010);
        end
        req_a     = 32'd100;
        req_b     = 32'd200;
        req_op    = 3'b010;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", req_ready, 0);
        end
        check("bp_head_valid", rsp_valid, 1);
        check("bp_head_z", rsp_z, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(32'd100, 32'd200, 3'b010);
        wait_drain();
        check("count_10", rsp_count, 10);

        // Random stream with toggling consumer
        cnt0   = rsp_count;
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            send(ra, rb, 3'($urandom_range(0, 7)));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_drain();
        dcnt = rsp_count - cnt0;
        check("count_1000", dcnt, 1000);
        check("count_total", rsp_count, n_pops[15:0]);

`ifdef ALU_RESPONDER_OVF_EN
        send(32'h7FFFFFFF, 32'd1, 3'b010);
        @(posedge clk);
        #1;
        check("ovf_add", ovf_obs, 1);
        send(32'h80000000, 32'd1, 3'b110);
        wait_drain();
`endif

        // Asynchronous reset with buffered results
        rsp_ready = 1'b0;
        send(32'd1, 32'd2, 3'b001);
        send(32'd3, 32'd4, 3'b010);
        send(32'd9, 32'd4, 3'b110);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", rsp_valid, 0);
        check("arst_count", rsp_count, 0);
        check("arst_ready", req_ready, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", rsp_valid, 0);
        check("post_rst_z", rsp_z, 0);
        check("post_rst_count", rsp_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
